alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl_pkg.sv | 53 +++++
 rtl/alu_issue_ctrl_if.sv | 41 ++++
 rtl/alu_issue_ctrl_instr_decode.sv | 102 ++++++++++
 rtl/alu_issue_ctrl.sv | 147 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// +--------------------------------------------------------------+
// | alu_issue_ctrl_pkg : shared opcodes, ALU codes, FSM states   |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

package alu_issue_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BGTZ     = 6'b000111;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_MOVZ = 6'b001010;
  localparam logic [5:0] FN_MOVN = 6'b001011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_CLZ  = 6'b100000;
  localparam logic [5:0] FN_CLO  = 6'b100001;

  localparam logic [2:0] ALU_RTYPE = 3'b000;
  localparam logic [2:0] ALU_EQ    = 3'b001;
  localparam logic [2:0] ALU_LT    = 3'b010;
  localparam logic [2:0] ALU_GT    = 3'b011;
  localparam logic [2:0] ALU_CNT   = 3'b100;
  localparam logic [2:0] ALU_ADDU  = 3'b101;
  localparam logic [2:0] ALU_ADDS  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
// +--------------------------------------------------------------+
// | alu_issue_ctrl_if : instruction, ALU and response signals    |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

interface alu_issue_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_code;
  logic [5:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_dest;
  logic        out_wr_en;
  logic        out_illegal;

  modport master (
    output instr_valid, instr, rs_val, rt_val, alu_result, alu_zero, out_ready,
    input  instr_ready, alu_a, alu_b, alu_code, alu_op,
           out_valid, out_result, out_zero, out_dest, out_wr_en, out_illegal
  );

  // alu_zero is redundant with alu_result == 0, so the controller does not take it
  modport slave (
    input  instr_valid, instr, rs_val, rt_val, alu_result, out_ready,
    output instr_ready, alu_a, alu_b, alu_code, alu_op,
           out_valid, out_result, out_zero, out_dest, out_wr_en, out_illegal
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue_ctrl_instr_decode.sv
// +--------------------------------------------------------------+
// | instr_decode : MIPS word -> ALU fields, dest, write, illegal |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

module instr_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [2:0]  alu_code_o,
  output logic [5:0]  alu_op_o,
  output logic [4:0]  dest_o,
  output logic        wr_en_o,
  output logic        illegal_o
);

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;
  logic        w_wr_raw;
  logic        unused_fields;

  assign w_opcode = instr_i[31:26];
  assign w_rt     = instr_i[20:16];
  assign w_rd     = instr_i[15:11];
  assign w_funct  = instr_i[5:0];
  assign w_imm    = instr_i[15:0];
  // rs arrives already read as rs_val; shamt is not forwarded to the ALU
  assign unused_fields = ^{instr_i[25:21], instr_i[10:6]};

  always_comb begin
    alu_a_o    = '0;
    alu_b_o    = '0;
    alu_code_o = ALU_RTYPE;
    alu_op_o   = '0;
    dest_o     = '0;
    w_wr_raw   = 1'b0;
    illegal_o  = 1'b0;
    case (w_opcode)
      OP_SPECIAL: begin
        alu_a_o  = rs_val_i;
        alu_b_o  = rt_val_i;
        alu_op_o = w_funct;
        dest_o   = w_rd;
        case (w_funct) inside
          FN_MOVZ: w_wr_raw = (rt_val_i == '0);
          FN_MOVN: w_wr_raw = (rt_val_i != '0);
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          [FN_ADD:FN_NOR], FN_SLT, FN_SLTU: w_wr_raw = 1'b1;
          default: illegal_o = 1'b1;
        endcase
      end
      OP_SPECIAL2: begin
        alu_a_o    = rs_val_i;
        alu_code_o = ALU_CNT;
        alu_op_o   = w_funct;
        dest_o     = w_rd;
        w_wr_raw   = 1'b1;
        if (w_funct != FN_CLZ && w_funct != FN_CLO) illegal_o = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI: begin
        alu_a_o    = rs_val_i;
        alu_b_o    = sext16(w_imm);
        alu_code_o = (w_opcode == OP_ADDI)  ? ALU_ADDS :
                     (w_opcode == OP_ADDIU) ? ALU_ADDU : ALU_LT;
        dest_o     = w_rt;
        w_wr_raw   = 1'b1;
      end
      OP_BEQ: begin
        alu_a_o    = rs_val_i;
        alu_b_o    = rt_val_i;
        alu_code_o = ALU_EQ;
      end
      OP_BGTZ: begin
        alu_a_o    = rs_val_i;
        alu_code_o = ALU_GT;
      end
      default: illegal_o = 1'b1;
    endcase
    if (illegal_o) begin
      alu_a_o    = '0;
      alu_b_o    = '0;
      alu_code_o = ALU_RTYPE;
      alu_op_o   = '0;
      dest_o     = '0;
      w_wr_raw   = 1'b0;
    end
  end

  // Writes to $zero are architecturally discarded
  assign wr_en_o = w_wr_raw && (dest_o != '0);

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// +--------------------------------------------------------------+
// | alu_issue_ctrl : single-in-flight ALU issue and response FSM |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  alu_issue_ctrl_if.slave   bus_io
);

  state_e      state_q, state_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]  alu_code_q, alu_code_d;
  logic [5:0]  alu_op_q, alu_op_d;
  logic [4:0]  dest_q, dest_d;
  logic        wr_q, wr_d;
  logic [31:0] res_q, res_d;
  logic        zero_q, zero_d;
  logic [4:0]  odest_q, odest_d;
  logic        owr_q, owr_d;
  logic        ill_q, ill_d;

  logic [31:0] w_dec_a, w_dec_b;
  logic [2:0]  w_dec_code;
  logic [5:0]  w_dec_op;
  logic [4:0]  w_dec_dest;
  logic        w_dec_wr, w_dec_ill;

  instr_decode u_decode (
    .instr_i    (bus_io.instr),
    .rs_val_i   (bus_io.rs_val),
    .rt_val_i   (bus_io.rt_val),
    .alu_a_o    (w_dec_a),
    .alu_b_o    (w_dec_b),
    .alu_code_o (w_dec_code),
    .alu_op_o   (w_dec_op),
    .dest_o     (w_dec_dest),
    .wr_en_o    (w_dec_wr),
    .illegal_o  (w_dec_ill)
  );

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_code_d = alu_code_q;
    alu_op_d   = alu_op_q;
    dest_d     = dest_q;
    wr_d       = wr_q;
    res_d      = res_q;
    zero_d     = zero_q;
    odest_d    = odest_q;
    owr_d      = owr_q;
    ill_d      = ill_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_io.instr_valid) begin
          if (w_dec_ill) begin
            state_d = ST_RESP;
            ill_d   = 1'b1;
          end else begin
            state_d    = ST_ISSUE;
            alu_a_d    = w_dec_a;
            alu_b_d    = w_dec_b;
            alu_code_d = w_dec_code;
            alu_op_d   = w_dec_op;
            dest_d     = w_dec_dest;
            wr_d       = w_dec_wr;
          end
        end
      end
      ST_ISSUE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        state_d    = ST_RESP;
        res_d      = bus_io.alu_result;
        zero_d     = (bus_io.alu_result == '0);
        odest_d    = dest_q;
        owr_d      = wr_q;
        alu_a_d    = '0;
        alu_b_d    = '0;
        alu_code_d = '0;
        alu_op_d   = '0;
      end
      ST_RESP: begin
        // Payload is cleared on handoff so it only ever shows a live response
        if (bus_io.out_ready) begin
          state_d = ST_IDLE;
          res_d   = '0;
          zero_d  = 1'b0;
          odest_d = '0;
          owr_d   = 1'b0;
          ill_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_code_q <= '0;
      alu_op_q   <= '0;
      dest_q     <= '0;
      wr_q       <= 1'b0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      odest_q    <= '0;
      owr_q      <= 1'b0;
      ill_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_code_q <= alu_code_d;
      alu_op_q   <= alu_op_d;
      dest_q     <= dest_d;
      wr_q       <= wr_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
      odest_q    <= odest_d;
      owr_q      <= owr_d;
      ill_q      <= ill_d;
    end
  end

  assign bus_io.instr_ready = (state_q == ST_IDLE);
  assign bus_io.alu_a       = alu_a_q;
  assign bus_io.alu_b       = alu_b_q;
  assign bus_io.alu_code    = alu_code_q;
  assign bus_io.alu_op      = alu_op_q;
  assign bus_io.out_valid   = (state_q == ST_RESP);
  assign bus_io.out_result  = res_q;
  assign bus_io.out_zero    = zero_q;
  assign bus_io.out_dest    = odest_q;
  assign bus_io.out_wr_en   = owr_q;
  assign bus_io.out_illegal = ill_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// +--------------------------------------------------------------+
// | tb_alu_issue_ctrl : directed scoreboard bench for the FSM    |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

module tb_alu_issue_ctrl;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  code;
    logic [5:0]  op;
    int          lat;
    logic [31:0] res;
    logic        zero;
    logic [4:0]  dest;
    logic        dchk;
    logic        wr;
    logic        ill;
  } exp_t;

  logic clk;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl u_dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lead(input logic [31:0] v, input logic bv);
    int  n = 0;
    bit  stop = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!stop) begin
        if (v[i] == bv) n++;
        else stop = 1'b1;
      end
    end
    return 32'(n);
  endfunction

  // Behavioural ALU standing in for the real datapath
  function automatic logic [31:0] alu_model(input logic [2:0] code, input logic [5:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    case (code)
      3'b110, 3'b101: return a + b;
      3'b010: return {31'b0, $signed(a) < $signed(b)};
      3'b001: return {31'b0, a == b};
      3'b011: return {31'b0, $signed(a) > $signed(b)};
      3'b100: return (op == 6'b100001) ? lead(a, 1'b1) : lead(a, 1'b0);
      default: begin
        case (op)
          6'b100000, 6'b100001: return a + b;
          6'b100010, 6'b100011: return a - b;
          6'b100100: return a & b;
          6'b100101: return a | b;
          6'b100110: return a ^ b;
          6'b100111: return ~(a | b);
          6'b101010: return {31'b0, $signed(a) < $signed(b)};
          6'b101011: return {31'b0, a < b};
          6'b001010, 6'b001011: return a;
          default: return b << a[4:0];
        endcase
      end
    endcase
  endfunction

  assign bus.alu_result = alu_model(bus.alu_code, bus.alu_op, bus.alu_a, bus.alu_b);
  assign bus.alu_zero   = (bus.alu_result == '0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] code,
                              input logic [5:0] op, input int lat, input logic [31:0] res,
                              input logic zero, input logic [4:0] dest, input logic dchk,
                              input logic wr, input logic ill);
    exp_t e;
    e.a = a; e.b = b; e.code = code; e.op = op; e.lat = lat; e.res = res;
    e.zero = zero; e.dest = dest; e.dchk = dchk; e.wr = wr; e.ill = ill;
    return e;
  endfunction

  task automatic check_payload(input string tag, input exp_t e);
    check({tag, ".result"}, bus.out_result, e.res);
    check({tag, ".zero"}, {31'b0, bus.out_zero}, {31'b0, e.zero});
    if (e.dchk) check({tag, ".dest"}, {27'b0, bus.out_dest}, {27'b0, e.dest});
    check({tag, ".wr_en"}, {31'b0, bus.out_wr_en}, {31'b0, e.wr});
    check({tag, ".illegal"}, {31'b0, bus.out_illegal}, {31'b0, e.ill});
  endtask

  task automatic run(input string tag, input logic [31:0] ins, input logic [31:0] rs,
                     input logic [31:0] rt, input exp_t e, input int hold);
    int   lat = 0;
    bit   got = 1'b0;
    exp_t p;
    @(negedge clk);
    check({tag, ".ready"}, {31'b0, bus.instr_ready}, 32'd1);
    bus.instr = ins; bus.rs_val = rs; bus.rt_val = rt; bus.instr_valid = 1'b1;
    sb.push_back(e);
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) got = 1'b1;
      else begin
        check({tag, ".alu_a"}, bus.alu_a, e.a);
        check({tag, ".alu_b"}, bus.alu_b, e.b);
        check({tag, ".alu_code"}, {29'b0, bus.alu_code}, {29'b0, e.code});
        check({tag, ".alu_op"}, {26'b0, bus.alu_op}, {26'b0, e.op});
        check({tag, ".busy"}, {31'b0, bus.instr_ready}, 32'd0);
        // Stray requests while busy must not disturb the held operands
        bus.instr = $urandom; bus.rs_val = $urandom; bus.rt_val = $urandom;
      end
    end
    bus.instr_valid = 1'b0;
    check({tag, ".latency"}, 32'(lat), 32'(e.lat));
    if (got) begin
      check({tag, ".resp_alu_code"}, {29'b0, bus.alu_code}, 32'd0);
      check({tag, ".resp_alu_a"}, bus.alu_a, 32'd0);
      if (sb.size() == 0) check({tag, ".sb_empty"}, 32'd0, 32'd1);
      else begin
        p = sb.pop_front();
        check_payload(tag, p);
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          check({tag, ".hold_valid"}, {31'b0, bus.out_valid}, 32'd1);
          check({tag, ".hold_ready"}, {31'b0, bus.instr_ready}, 32'd0);
          check_payload({tag, ".hold"}, p);
        end
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, ".done_valid"}, {31'b0, bus.out_valid}, 32'd0);
      check({tag, ".done_ready"}, {31'b0, bus.instr_ready}, 32'd1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".alu_a"}, bus.alu_a, 32'd0);
    check({tag, ".alu_b"}, bus.alu_b, 32'd0);
    check({tag, ".alu_code"}, {29'b0, bus.alu_code}, 32'd0);
    check({tag, ".alu_op"}, {26'b0, bus.alu_op}, 32'd0);
    check({tag, ".valid"}, {31'b0, bus.out_valid}, 32'd0);
    check_payload(tag, mk(0, 0, 0, 0, 0, 0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.instr_valid = 1'b0; bus.instr = '0; bus.rs_val = '0; bus.rt_val = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check("reset.ready", {31'b0, bus.instr_ready}, 32'd1);

    run("addi", 32'h2008FFFF, 32'd5, 32'd0,
        mk(32'd5, 32'hFFFFFFFF, 3'b110, 6'd0, 3, 32'd4, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0), 0);
    run("beq", 32'h10220010, 32'd7, 32'd7,
        mk(32'd7, 32'd7, 3'b001, 6'd0, 3, 32'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), 0);
    run("movz_nz", 32'h0085300A, 32'h1234, 32'd3,
        mk(32'h1234, 32'd3, 3'b000, 6'h0A, 3, 32'h1234, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0), 0);
    run("movz_z", 32'h0085300A, 32'h1234, 32'd0,
        mk(32'h1234, 32'd0, 3'b000, 6'h0A, 3, 32'h1234, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0), 0);
    run("movn_nz", 32'h0085300B, 32'h55, 32'd3,
        mk(32'h55, 32'd3, 3'b000, 6'h0B, 3, 32'h55, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0), 0);
    run("illegal_op", 32'hFC000000, 32'h11, 32'h22,
        mk(32'd0, 32'd0, 3'b000, 6'd0, 1, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1), 0);
    run("add_hold", 32'h00221820, 32'd10, 32'd20,
        mk(32'd10, 32'd20, 3'b000, 6'h20, 3, 32'd30, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0), 4);
    run("add_rd0", 32'h00220020, 32'd0, 32'd0,
        mk(32'd0, 32'd0, 3'b000, 6'h20, 3, 32'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0), 0);
    run("slti", 32'h2809FFFF, 32'hFFFFFFFE, 32'd0,
        mk(32'hFFFFFFFE, 32'hFFFFFFFF, 3'b010, 6'd0, 3, 32'd1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0), 0);
    run("clz", 32'h70202020, 32'h00010000, 32'hDEAD,
        mk(32'h00010000, 32'd0, 3'b100, 6'h20, 3, 32'd15, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0), 0);
    run("illegal_fn", 32'h00000001, 32'd1, 32'd2,
        mk(32'd0, 32'd0, 3'b000, 6'd0, 1, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1), 0);
    run("bgtz", 32'h1C200004, 32'd5, 32'd9,
        mk(32'd5, 32'd0, 3'b011, 6'd0, 3, 32'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), 0);

    // Abort an ADD while it sits in CAPTURE
    @(negedge clk);
    bus.instr = 32'h00221820; bus.rs_val = 32'd10; bus.rt_val = 32'd20; bus.instr_valid = 1'b1;
    sb.push_back(mk(32'd10, 32'd20, 3'b000, 6'h20, 3, 32'd30, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0));
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    check("abort.capture_code", {26'b0, bus.alu_op}, 32'h20);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    sb.delete();
    reset = 1'b0;
    @(negedge clk);
    check("abort.ready", {31'b0, bus.instr_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("abort.no_valid", {31'b0, bus.out_valid}, 32'd0);
      @(negedge clk);
    end
    check("sb.drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
